// File: rtl/pair_triple_debouncer.sv
// Debounces the pair/triple detector result: the filtered value flips only after p_hold
// consecutive disagreeing valid samples, with rise/fall pulses and a saturating rise count.
module pair_triple_debouncer #(
    parameter int unsigned p_hold = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_val,
    input  logic       det,
    input  logic       cnt_clr,
    output logic       filt,
    output logic       rise,
    output logic       fall,
    output logic [7:0] evt_cnt
);

    localparam logic [3:0] HoldCnt = 4'(p_hold);

    typedef enum logic [1:0] {
        StLo,
        StLoPend,
        StHi,
        StHiPend
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       filt_q, filt_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [7:0] cnt_q, cnt_d;
    logic       cur_hi;
    logic [3:0] run_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLo;
            run_q   <= 4'd0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        filt_d  = filt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;
        cur_hi  = 1'b0;
        run_inc = run_q + 4'd1;

        unique case (state_q)
            StHi, StHiPend: cur_hi = 1'b1;
            default:        cur_hi = 1'b0;
        endcase

        // Invalid cycles hold the run so gaps in the sample stream do not reset it.
        if (det_val) begin
            if (det == cur_hi) begin
                state_d = cur_hi ? StHi : StLo;
                run_d   = 4'd0;
            end else if (run_inc == HoldCnt) begin
                state_d = cur_hi ? StLo : StHi;
                run_d   = 4'd0;
                filt_d  = ~cur_hi;
                rise_d  = ~cur_hi;
                fall_d  = cur_hi;
            end else begin
                state_d = cur_hi ? StHiPend : StLoPend;
                run_d   = run_inc;
            end
        end

        // Clear takes priority over a coincident rising event.
        if (cnt_clr) begin
            cnt_d = 8'd0;
        end else if (rise_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign filt    = filt_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt_cnt = cnt_q;

endmodule

// File: tb/tb_pair_triple_debouncer.sv
// Directed bench for pair_triple_debouncer: a p_hold=3 instance plus a p_hold=1 instance
// sharing clock, reset and counter clear.
module tb_pair_triple_debouncer;

    logic       clk;
    logic       rst;
    logic       cnt_clr;
    logic       dv, d;
    logic       filt, rise, fall;
    logic [7:0] cnt;
    logic       dv1, d1;
    logic       filt1, rise1, fall1;
    logic [7:0] cnt1;

    int n_chk;
    int n_pass;

    pair_triple_debouncer #(.p_hold(3)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .det_val (dv),
        .det     (d),
        .cnt_clr (cnt_clr),
        .filt    (filt),
        .rise    (rise),
        .fall    (fall),
        .evt_cnt (cnt)
    );

    pair_triple_debouncer #(.p_hold(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .det_val (dv1),
        .det     (d1),
        .cnt_clr (cnt_clr),
        .filt    (filt1),
        .rise    (rise1),
        .fall    (fall1),
        .evt_cnt (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one sample to the p_hold=3 instance, then settle past the edge.
    task automatic tick(input logic v, input logic x);
        dv = v;
        d  = x;
        @(posedge clk);
        #1;
    endtask

    task automatic tick1(input logic v, input logic x);
        dv1 = v;
        d1  = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        cnt_clr = 1'b0;
        dv      = 1'b1;
        d       = 1'b1;
        dv1     = 1'b0;
        d1      = 1'b0;

        // Reset held two cycles with det_val=1, det=1
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1);
            check("rst_filt", int'(filt), 0);
            check("rst_rise", int'(rise), 0);
            check("rst_fall", int'(fall), 0);
            check("rst_cnt", int'(cnt), 0);
        end
        rst = 1'b0;
        tick(1'b0, 1'b1);
        check("post_rst_filt", int'(filt), 0);
        check("post_rst_rise", int'(rise), 0);
        check("post_rst_cnt", int'(cnt), 0);

        // Glitch rejection: 1,1,0,1,1,0 never reaches three in a row
        begin
            logic [5:0] glitch;
            glitch = 6'b011011;
            for (int i = 0; i < 6; i++) begin
                tick(1'b1, glitch[i]);
                check("glitch_filt", int'(filt), 0);
                check("glitch_rise", int'(rise), 0);
            end
            check("glitch_cnt", int'(cnt), 0);
        end

        // Rise with invalid gaps: valid 1s at cycles 0, 2, 5
        tick(1'b1, 1'b1);
        check("gap_filt0", int'(filt), 0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        check("gap_filt2", int'(filt), 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("gap_filt4", int'(filt), 0);
        check("gap_rise4", int'(rise), 0);
        tick(1'b1, 1'b1);
        check("gap_filt5", int'(filt), 1);
        check("gap_rise5", int'(rise), 1);
        check("gap_fall5", int'(fall), 0);
        check("gap_cnt5", int'(cnt), 1);
        tick(1'b0, 1'b0);
        check("gap_rise_end", int'(rise), 0);
        check("gap_filt_hold", int'(filt), 1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("fall_pend", int'(filt), 1);
        tick(1'b1, 1'b0);
        check("fall_filt", int'(filt), 0);
        check("fall_pulse", int'(fall), 1);
        check("fall_norise", int'(rise), 0);
        check("fall_cnt", int'(cnt), 1);
        tick(1'b1, 1'b0);
        check("fall_end", int'(fall), 0);

        // Clear alone, then 256 rise/fall cycles to saturate
        cnt_clr = 1'b1;
        tick(1'b0, 1'b0);
        cnt_clr = 1'b0;
        check("clr_cnt", int'(cnt), 0);
        check("clr_filt", int'(filt), 0);
        for (int k = 1; k <= 256; k++) begin
            for (int j = 0; j < 3; j++) tick(1'b1, 1'b1);
            exp_cnt = (k > 255) ? 255 : k;
            if (k == 1 || k >= 254) begin
                check("sat_rise", int'(rise), 1);
            end
            check("sat_cnt", int'(cnt), exp_cnt);
            for (int j = 0; j < 3; j++) tick(1'b1, 1'b0);
        end
        check("sat_hold", int'(cnt), 255);
        // 257th rise with a coincident clear
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        cnt_clr = 1'b1;
        tick(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("clr_win_cnt", int'(cnt), 0);
        check("clr_win_rise", int'(rise), 1);
        check("clr_win_filt", int'(filt), 1);
        for (int j = 0; j < 3; j++) tick(1'b1, 1'b0);
        check("back_lo", int'(filt), 0);

        // Reset mid-run discards the pending count
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b1);
        rst = 1'b0;
        check("midrst_cnt", int'(cnt), 0);
        tick(1'b1, 1'b1);
        check("midrst_filt1", int'(filt), 0);
        tick(1'b1, 1'b1);
        check("midrst_filt2", int'(filt), 0);
        tick(1'b1, 1'b1);
        check("midrst_filt3", int'(filt), 1);
        check("midrst_rise", int'(rise), 1);
        check("midrst_cnt3", int'(cnt), 1);
        tick(1'b0, 1'b0);

        // p_hold=1 instance: 1,0,1
        tick1(1'b1, 1'b1);
        check("h1_filt_a", int'(filt1), 1);
        check("h1_rise_a", int'(rise1), 1);
        check("h1_fall_a", int'(fall1), 0);
        tick1(1'b1, 1'b0);
        check("h1_filt_b", int'(filt1), 0);
        check("h1_rise_b", int'(rise1), 0);
        check("h1_fall_b", int'(fall1), 1);
        tick1(1'b1, 1'b1);
        check("h1_filt_c", int'(filt1), 1);
        check("h1_rise_c", int'(rise1), 1);
        check("h1_fall_c", int'(fall1), 0);
        check("h1_cnt", int'(cnt1), 2);
        tick1(1'b0, 1'b0);
        check("h1_rise_end", int'(rise1), 0);
        check("h1_filt_hold", int'(filt1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pair_triple_debouncer.md
# pair_triple_debouncer

Downstream consumer of the pair/triple detector output. Samples the detector's 1-bit result under a valid qualifier and filters it: the filtered output changes only after `p_hold` consecutive valid samples disagree with it. Emits one-cycle rise/fall pulses on each filtered transition and keeps a saturating count of rising events for the status logic.

## Interface

- `p_hold`, default 3, number of consecutive disagreeing valid samples required to flip the filtered output; legal range 1..15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `det_val`  input  1  high when `det` carries a sample this cycle.
- `det`  input  1  detector output (1 = two or more of the three inputs high).
- `cnt_clr`  input  1  synchronous clear of `evt_cnt` only.
- `filt`  output  1  debounced detector value.
- `rise`  output  1  one-cycle pulse: `filt` went 0→1 on the last edge.
- `fall`  output  1  one-cycle pulse: `filt` went 1→0 on the last edge.
- `evt_cnt`  output  8  number of rising events since reset/clear, saturating at 255.

## Operation

- State machine, 4 states: `LO` (filt=0, stable), `LO_PEND` (filt=0, run of det=1 in progress), `HI` (filt=1, stable), `HI_PEND` (filt=1, run of det=0 in progress).
- 4-bit run counter `run` counts consecutive disagreeing valid samples.
- Edge with `det_val`=0: state, `run`, `filt` held; `rise`/`fall` cleared to 0; `evt_cnt` changes only via `cnt_clr`. Invalid cycles do not break a run.
- Edge with `det_val`=1 and `det`==`filt`: go to `LO`/`HI` (the stable state for current `filt`), `run`←0.
- Edge with `det_val`=1 and `det`!=`filt`:
  - if `run`+1 == `p_hold`: flip `filt`, `run`←0, go to the opposite stable state; assert `rise` (0→1) or `fall` (1→0).
  - else: `run`←`run`+1, go to/stay in the pending state.
- `p_hold`=1: first disagreeing valid sample flips `filt`; pending states are never entered.
- `evt_cnt`: +1 on each edge that sets `rise`; holds at 255 (no wrap).
- `cnt_clr`=1: `evt_cnt`←0 on that edge; wins over a simultaneous increment. Does not affect `filt`, `run`, state, or pulses.
- `rise` and `fall` are never high together; each is high for exactly one cycle per transition.

## Timing

- Reset (edge with `rst`=1): state `LO`, `run`=0, `filt`=0, `rise`=0, `fall`=0, `evt_cnt`=0. Reset overrides all other inputs, including mid-run; pending runs are discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: with an uninterrupted valid stream, `filt` changes in the cycle after the edge that samples the `p_hold`-th consecutive disagreeing sample. `rise`/`fall` and the updated `evt_cnt` are visible in that same cycle.
- Minimum spacing between two transitions is `p_hold` valid samples.
- A pulse asserted on edge k is deasserted on edge k+1 regardless of `det_val`.

## Test plan

- Reset: assert `rst` for 2 cycles with `det_val`=1, `det`=1 → `filt`=0, `rise`=0, `fall`=0, `evt_cnt`=0 throughout and on the first cycle after release.
- Glitch rejection (`p_hold`=3): valid `det` = 1,1,0,1,1,0 → `filt` stays 0, no pulses, `evt_cnt`=0.
- Rise with gaps: valid `det`=1 at cycles 0, 2, 5 (`det_val`=0 between) → `filt`=1 and `rise`=1 in cycle 6 only, `evt_cnt`=1; then valid `det`=0 ×3 → `fall`=1 for one cycle, `filt`=0, `evt_cnt` still 1.
- Saturation and clear: drive 256 complete rise/fall cycles → `evt_cnt` reaches 255 and holds; assert `cnt_clr` on the same edge as a 257th rise → `evt_cnt`=0, `rise`=1, `filt`=1.
- Reset mid-run: two valid `det`=1 samples, then `rst` for 1 cycle, then one valid `det`=1 → `filt` remains 0 (run restarted from 0); two more valid 1s → `filt`=1.
- `p_hold`=1 instance: valid `det` = 1,0,1 → `filt` = 1,0,1 one cycle later each, alternating `rise`/`fall` pulses, `evt_cnt`=2.
